// File: rtl/pp_sched.sv
// rtl/pp_sched.sv - round-robin command scheduler for the pp column datapath
module pp_sched #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_SIZE = 32,
  parameter int LEN_W    = 16,
  parameter int OP_W     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*OP_W-1:0]      req_op,
  input  logic [NUM_REQ*LEN_W-1:0]     req_len,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           req_done,
  input  logic [NUM_REQ*NUM_SIZE-1:0]  src_data,
  input  logic [NUM_REQ-1:0]           src_valid,
  output logic [NUM_REQ-1:0]           src_ready,
  output logic [OP_W-1:0]              dp_cmd,
  output logic [NUM_SIZE-1:0]          dp_in1,
  output logic                         dp_in_valid,
  input  logic                         dp_valid,
  output logic                         err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  ptr, g, pick, cand;
  logic              found;
  logic [OP_W-1:0]   op;
  logic [LEN_W-1:0]  len, issued, returned, issued_n, returned_n;
  logic              beat, ret, err_hit;

  logic [OP_W-1:0]     op_a   [NUM_REQ];
  logic [LEN_W-1:0]    len_a  [NUM_REQ];
  logic [NUM_SIZE-1:0] data_a [NUM_REQ];

  // Unpack the per-requester slices so they can be indexed by grant id
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign op_a[i]   = req_op[i*OP_W +: OP_W];
    assign len_a[i]  = req_len[i*LEN_W +: LEN_W];
    assign data_a[i] = src_data[i*NUM_SIZE +: NUM_SIZE];
  end

  // Round-robin pick: first pending requester at or after ptr, with wrap
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    cand  = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Beat/return qualification and next counter values
  always_comb begin
    beat       = (state == ISSUE) && src_valid[g] && (issued < len);
    ret        = dp_valid && ((state == ISSUE) || (state == DRAIN)) && (returned < len);
    issued_n   = issued + LEN_W'(beat);
    returned_n = returned + LEN_W'(ret);
    err_hit    = (dp_valid && ((state == IDLE) || (state == DONE) ||
                               (returned == len)))
              || ((state == IDLE) && found && (op_a[pick] == '0));
  end

  // Next-state and datapath/handshake outputs; everything forced idle in reset
  always_comb begin
    state_n     = state;
    req_ready   = '0;
    req_done    = '0;
    src_ready   = '0;
    dp_cmd      = '0;
    dp_in1      = '0;
    dp_in_valid = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          req_ready[pick] = 1'b1;
          state_n = (len_a[pick] == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        dp_cmd       = op;
        src_ready[g] = (issued < len);
        dp_in_valid  = beat;
        dp_in1       = beat ? data_a[g] : '0;
        if (issued_n == len)
          state_n = (returned_n == len) ? DONE : DRAIN;
      end
      DRAIN: begin
        dp_cmd = op;
        if (returned_n == len)
          state_n = DONE;
      end
      DONE: begin
        req_done[g] = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (!reset) begin
      state_n     = IDLE;
      req_ready   = '0;
      req_done    = '0;
      src_ready   = '0;
      dp_cmd      = '0;
      dp_in1      = '0;
      dp_in_valid = 1'b0;
    end
  end

  // Command registers, counters, round-robin pointer and sticky error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      g        <= '0;
      op       <= '0;
      len      <= '0;
      issued   <= '0;
      returned <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_n;
      if (err_hit)
        err <= 1'b1;
      case (state)
        IDLE: begin
          if (found) begin
            g        <= pick;
            op       <= op_a[pick];
            len      <= len_a[pick];
            issued   <= '0;
            returned <= '0;
          end
        end
        ISSUE, DRAIN: begin
          issued   <= issued_n;
          returned <= returned_n;
        end
        DONE: ptr <= (g == IDX_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pp_sched.sv
// tb/tb_pp_sched.sv - directed self-checking bench for pp_sched
module tb_pp_sched;

  localparam int NUM_REQ  = 4;
  localparam int NUM_SIZE = 32;
  localparam int LEN_W    = 16;
  localparam int OP_W     = 4;

  logic                        clk;
  logic                        reset;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*OP_W-1:0]     req_op;
  logic [NUM_REQ*LEN_W-1:0]    req_len;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ-1:0]          req_done;
  logic [NUM_REQ*NUM_SIZE-1:0] src_data;
  logic [NUM_REQ-1:0]          src_valid;
  logic [NUM_REQ-1:0]          src_ready;
  logic [OP_W-1:0]             dp_cmd;
  logic [NUM_SIZE-1:0]         dp_in1;
  logic                        dp_in_valid;
  logic                        dp_valid;
  logic                        err;

  int n_tests = 0;
  int n_fail  = 0;
  int beats;
  logic [5:0] stall_pat;
  logic [3:0] rr_exp [5];

  pp_sched #(.NUM_REQ(NUM_REQ), .NUM_SIZE(NUM_SIZE), .LEN_W(LEN_W), .OP_W(OP_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_len(req_len),
    .req_ready(req_ready), .req_done(req_done),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .dp_cmd(dp_cmd), .dp_in1(dp_in1), .dp_in_valid(dp_in_valid),
    .dp_valid(dp_valid), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int op, input int len);
    req_op[i*OP_W +: OP_W]    = OP_W'(op);
    req_len[i*LEN_W +: LEN_W] = LEN_W'(len);
  endtask

  task automatic set_data(input int i, input int v);
    src_data[i*NUM_SIZE +: NUM_SIZE] = NUM_SIZE'(v);
  endtask

  task automatic do_reset();
    req_valid = '0;
    src_valid = '0;
    dp_valid  = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; req_valid = '0; req_op = '0; req_len = '0;
    src_data = '0; src_valid = '0; dp_valid = 1'b0;
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    #12;
    check("rst_ready", req_ready, 0);
    check("rst_done", req_done, 0);
    check("rst_src_ready", src_ready, 0);
    check("rst_in_valid", dp_in_valid, 0);
    check("rst_cmd", dp_cmd, 0);
    check("rst_in1", dp_in1, 0);
    check("rst_err", err, 0);
    tick();
    reset = 1'b1;

    // single command, 2-cycle datapath latency
    set_req(0, 1, 3); set_data(0, 10);
    req_valid = 4'b0001; src_valid = 4'b0001; #1;
    check("t1_ready", req_ready, 4'b0001);
    check("t1_cmd_idle", dp_cmd, 0);
    tick(); req_valid = '0; #1;
    check("t1_v1", dp_in_valid, 1); check("t1_d1", dp_in1, 10);
    check("t1_cmd1", dp_cmd, 1);    check("t1_srdy", src_ready, 4'b0001);
    tick(); set_data(0, 11); #1;
    check("t1_v2", dp_in_valid, 1); check("t1_d2", dp_in1, 11);
    tick(); set_data(0, 12); dp_valid = 1'b1; #1;
    check("t1_v3", dp_in_valid, 1); check("t1_d3", dp_in1, 12);
    tick(); #1;
    check("t1_v4", dp_in_valid, 0); check("t1_d4", dp_in1, 0);
    check("t1_cmd4", dp_cmd, 1);    check("t1_srdy4", src_ready, 0);
    tick(); #1;
    check("t1_cmd5", dp_cmd, 1); check("t1_done5", req_done, 0);
    tick(); dp_valid = 1'b0; #1;
    check("t1_done6", req_done, 4'b0001); check("t1_cmd6", dp_cmd, 0);
    tick(); #1;
    check("t1_done7", req_done, 0); check("t1_err", err, 0);

    // round-robin with all requesters pending
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      set_req(i, 2, 1);
      set_data(i, 20 + i);
    end
    req_valid = 4'b1111; src_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("rr_ready%0d", k), req_ready, rr_exp[k]);
      tick(); #1;
      check($sformatf("rr_beat%0d", k), dp_in_valid, 1);
      tick(); dp_valid = 1'b1; #1;
      tick(); dp_valid = 1'b0; #1;
      check($sformatf("rr_done%0d", k), req_done, rr_exp[k]);
      tick();
    end

    // zero length
    do_reset();
    set_req(2, 5, 0);
    req_valid = 4'b0100; #1;
    check("z_ready", req_ready, 4'b0100);
    tick(); req_valid = '0; #1;
    check("z_done", req_done, 4'b0100);
    check("z_in_valid", dp_in_valid, 0);
    check("z_cmd", dp_cmd, 0);
    tick(); req_valid = 4'b1111; #1;
    check("z_ptr3", req_ready, 4'b1000);

    // operand stall
    do_reset();
    set_req(1, 3, 4);
    req_valid = 4'b0010; #1;
    check("s_ready", req_ready, 4'b0010);
    tick(); req_valid = '0;
    stall_pat = 6'b110101;
    beats = 0;
    for (int c = 0; c < 6; c++) begin
      src_valid = {2'b00, stall_pat[c], 1'b0};
      set_data(1, 100 + c); #1;
      check($sformatf("s_valid%0d", c), dp_in_valid, stall_pat[c]);
      check($sformatf("s_data%0d", c), dp_in1, stall_pat[c] ? 64'(100 + c) : 64'd0);
      check($sformatf("s_srdy%0d", c), src_ready, 4'b0010);
      if (dp_in_valid) beats++;
      tick();
    end
    src_valid = 4'b0010; dp_valid = 1'b1; #1;
    check("s_beats", beats, 4);
    check("s_srdy_drop", src_ready, 0);
    check("s_no_beat", dp_in_valid, 0);
    repeat (4) tick();
    dp_valid = 1'b0; #1;
    check("s_done", req_done, 4'b0010);
    check("s_err", err, 0);

    // errors: dp_valid in IDLE, then excess return
    do_reset(); #1;
    check("e_err0", err, 0);
    dp_valid = 1'b1;
    tick(); dp_valid = 1'b0; #1;
    check("e_idle_err", err, 1);
    repeat (3) tick(); #1;
    check("e_sticky", err, 1);
    do_reset(); #1;
    check("e_err_clr", err, 0);
    set_req(0, 6, 4);
    req_valid = 4'b0001; src_valid = '0;
    tick(); req_valid = '0; dp_valid = 1'b1;
    repeat (4) tick(); #1;
    check("e_err_4th", err, 0);
    tick(); dp_valid = 1'b0; src_valid = 4'b0001; #1;
    check("e_err_5th", err, 1);
    check("e_beat", dp_in_valid, 1);
    repeat (4) tick(); src_valid = '0; #1;
    check("e_done", req_done, 4'b0001);
    tick(); #1;
    check("e_done_once", req_done, 0);

    // async reset mid-issue, then grant from ptr=0 with a NOOP request
    do_reset();
    set_req(0, 4, 5); set_data(0, 55);
    req_valid = 4'b0001; src_valid = 4'b0001;
    tick(); req_valid = '0;
    tick(); #1;
    check("a_beat", dp_in_valid, 1);
    tick(); #1;
    req_valid = 4'b1111;
    reset = 1'b0; #1;
    check("a_ready", req_ready, 0);
    check("a_in_valid", dp_in_valid, 0);
    check("a_cmd", dp_cmd, 0);
    check("a_in1", dp_in1, 0);
    check("a_srdy", src_ready, 0);
    check("a_done", req_done, 0);
    tick(); tick();
    reset = 1'b1;
    set_req(3, 0, 0);
    req_valid = 4'b1000; #1;
    check("a_grant3", req_ready, 4'b1000);
    tick(); req_valid = '0; #1;
    check("a_done3", req_done, 4'b1000);
    check("a_noop_err", err, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pp_sched.md
# pp_sched

Command scheduler for the pp column datapath. It arbitrates round-robin among NUM_REQ requesters, each of which submits an opcode and an element count. For the granted requester it drives the opcode onto the datapath, streams that requester's operands through, counts the returned results, and signals per-requester completion. It sits between the host-side request queues and the single pp datapath instance.

## Interface
- NUM_REQ, 4, number of requesters (≥2)
- NUM_SIZE, 32, operand width
- LEN_W, 16, element-count width
- OP_W, 4, opcode width; opcode 0 = NOOP

- clk  in  1  clock, all logic rising-edge
- reset  in  1  asynchronous, active-low (asserted at 0)
- req_valid  in  NUM_REQ  request pending per requester
- req_op  in  NUM_REQ*OP_W  opcode, slice i for requester i
- req_len  in  NUM_REQ*LEN_W  element count, slice i
- req_ready  out  NUM_REQ  one-hot accept; handshake = req_valid[i] & req_ready[i]
- req_done  out  NUM_REQ  one-cycle completion pulse
- src_data  in  NUM_REQ*NUM_SIZE  operand stream, slice i
- src_valid  in  NUM_REQ  operand valid
- src_ready  out  NUM_REQ  operand consumed when src_valid & src_ready
- dp_cmd  out  OP_W  opcode to datapath
- dp_in1  out  NUM_SIZE  operand to datapath
- dp_in_valid  out  1  dp_in1 valid this cycle
- dp_valid  in  1  datapath result valid (no backpressure)
- err  out  1  sticky protocol error

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: if any req_valid, select g = first set bit searching from ptr upward, with wrap. Assert req_ready[g] combinationally in the same cycle. Register op, len, g and zero both counters (issued, returned).
  - len == 0 → DONE.
  - Otherwise → ISSUE.
- ISSUE: dp_cmd = op.
  - src_ready[g] = (issued < len); src_ready of all other requesters = 0.
  - dp_in1 = src_data[g]; dp_in_valid = src_valid[g] & (issued < len).
  - issued increments on each beat.
  - Once issued == len: → DONE if returned == len (counting the current cycle's dp_valid), else → DRAIN.
- DRAIN: dp_cmd = op; dp_in_valid = 0; → DONE when returned reaches len.
- returned increments on dp_valid in ISSUE and DRAIN.
- DONE: req_done[g] = 1 for this cycle; ptr ← (g+1) mod NUM_REQ; → IDLE.
- dp_cmd = NOOP in IDLE and DONE. dp_in1 = 0 whenever dp_in_valid = 0.
- err set (sticky until reset) when any of the following occurs:
  - dp_valid in IDLE or DONE;
  - dp_valid while returned == len;
  - req_op == NOOP on an accepted request. Such a request is still sequenced normally.
- Counters are LEN_W bits wide and never exceed len; no wrap is possible.
- Requests that are not granted keep req_valid and their payload stable until accepted. The scheduler does not latch them.

## Timing
- Reset (async assert) forces immediately:
  - state = IDLE, ptr = 0, counters = 0, err = 0;
  - req_ready, req_done, src_ready, dp_in_valid = 0;
  - dp_cmd = NOOP, dp_in1 = 0.
- Reset deassertion is synchronous to clk.
- Reset mid-operation abandons the command. No req_done is issued.
- Request accepted at cycle T:
  - ISSUE is entered at T+1; the first dp_in_valid can occur at T+1.
  - For len == 0: req_done at T+1.
- Last result (dp_valid) at cycle R → req_done at R+1, IDLE at R+2. The earliest next accept is R+2.
- Full-rate issue: with src_valid held high, dp_in_valid is high for exactly len consecutive cycles starting at T+1.
- dp_valid coincident with dp_in_valid (zero-latency datapath) is legal and counted in that cycle.
- Only one command is in flight at a time. req_ready is never asserted outside IDLE.

## Test plan
- Single command: req0 op=1, len=3, src0 always valid (data 10, 11, 12); datapath returns with 2-cycle latency. Required: dp_in_valid on T+1..T+3 with 10, 11, 12; dp_cmd=1 T+1..T+5; req_done[0] at T+6; err=0.
- Round-robin: req_valid=4'b1111 held, all len=1, 1-cycle datapath. Required: grant order 0, 1, 2, 3, 0; each req_done pulses once per grant.
- Zero length: req2 len=0 accepted at T. Required: req_done[2] at T+1; no dp_in_valid; dp_cmd stays NOOP; ptr=3.
- Operand stall: req1 len=4, src_valid[1] pattern 1,0,1,0,1,1. Required: exactly 4 dp_in_valid beats, only on cycles where src_valid is set; src_ready[1] drops after the 4th beat.
- Errors: dp_valid pulsed in IDLE → err=1 and stays 1. After reset: a 5th dp_valid on a len=4 command → err=1, and req_done still fires once.
- Async reset: assert reset during ISSUE with issued=2 of 5. Required: all outputs 0/NOOP immediately; no req_done; after release a new req3 request is granted using ptr=0 search order.
